// File: rtl/divider_rate_ctrl_pkg.sv
// Shared constants for the run-time clock divider controller.
//   N_DEFAULT            default width of the half-period counter / config word
//   DEFAULT_HALF_DEFAULT default half-period (Clk_in cycles) loaded at reset
//   MIN_HALF             smallest half-period ever put in force (Clk_in/2)
//   ST_*                 controller state encoding (2-bit)
package divider_rate_ctrl_pkg;

  localparam int N_DEFAULT            = 16;
  localparam int DEFAULT_HALF_DEFAULT = 12500;
  localparam int MIN_HALF             = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

endpackage

// File: rtl/divider_rate_ctrl_counter.sv
// Half-period counter and divided-clock toggle flop.
//   clk_i      board clock
//   rst_i      asynchronous active-high reset
//   clr_i      synchronous clear: counter to 0, divided clock low
//   half_i     half-period in force (>= 1)
//   tc_o       terminal count: counter == half_i - 1
//   div_clk_o  registered divided clock
module half_period_counter #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [N-1:0] half_i,
  output logic         tc_o,
  output logic         div_clk_o
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         div_clk_q, div_clk_d;

  // half_i is never 0, so the compare value never underflows and the
  // counter never runs past half_i - 1
  assign tc_o      = (cnt_q == (half_i - N'(1)));
  assign div_clk_o = div_clk_q;

  // Next-state: clear wins, terminal count toggles and restarts, else count
  always_comb begin
    cnt_d     = cnt_q;
    div_clk_d = div_clk_q;
    if (clr_i) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
    end else if (tc_o) begin
      cnt_d     = '0;
      div_clk_d = ~div_clk_q;
    end else begin
      cnt_d     = cnt_q + N'(1);
      div_clk_d = div_clk_q;
    end
  end

  // Counter and toggle flop state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_clk_q <= div_clk_d;
    end
  end

endmodule

// File: rtl/divider_rate_ctrl.sv
// Run-time rate controller for a 50%-duty clock divider. Rate changes and
// stops only take effect at a falling edge of the divided clock (or at the
// end of a low phase already in progress), so no runt phase is produced.
//   Clk_in       board clock
//   Rst          asynchronous active-high reset
//   Run_en       1 = run divided clock, 0 = stop at next low boundary
//   Cfg_valid    new half-period offered
//   Cfg_half     requested half-period (0 and 1 both mean 1)
//   Cfg_ready    config can be accepted this cycle (IDLE or RUN)
//   Clk_o        registered divided clock
//   Tick_o       one-cycle pulse in the first cycle Clk_o reads 1
//   Active_half  half-period currently in force
//   Busy         high in RUN, PEND and STOP
module divider_rate_ctrl
  import divider_rate_ctrl_pkg::*;
#(
  parameter int N            = N_DEFAULT,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
  input  logic         Clk_in,
  input  logic         Rst,
  input  logic         Run_en,
  input  logic         Cfg_valid,
  input  logic [N-1:0] Cfg_half,
  output logic         Cfg_ready,
  output logic         Clk_o,
  output logic         Tick_o,
  output logic [N-1:0] Active_half,
  output logic         Busy
);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] active_q, active_d;
  logic [N-1:0] pend_q, pend_d;
  logic         pflag_q, pflag_d;
  logic         tick_q, tick_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic         tc;
  logic         div_clk;
  logic         clr;
  logic         accept;
  logic         fall;
  logic [N-1:0] cfg_clamped;

  assign accept      = Cfg_valid && ready_q;
  assign cfg_clamped = (Cfg_half <= N'(MIN_HALF)) ? N'(MIN_HALF) : Cfg_half;
  assign fall        = tc && div_clk;
  // IDLE holds the counter clear; a STOP boundary returns it to clear, which
  // also suppresses the toggle when the stop lands on a low-phase end
  assign clr         = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tc);

  half_period_counter #(.N(N)) u_cnt (
    .clk_i     (Clk_in),
    .rst_i     (Rst),
    .clr_i     (clr),
    .half_i    (active_q),
    .tc_o      (tc),
    .div_clk_o (div_clk)
  );

  // Controller FSM: state, active half-period and pending config
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          active_d = cfg_clamped;
        end else begin
          active_d = active_q;
        end
        if (Run_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          pend_d = cfg_clamped;
          if (Run_en) begin
            state_d = ST_PEND;
          end else begin
            state_d = ST_STOP;
            pflag_d = 1'b1;
          end
        end else if (!Run_en) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PEND: begin
        if (fall) begin
          active_d = pend_q;
          pflag_d  = 1'b0;
          state_d  = Run_en ? ST_RUN : ST_STOP;
        end else if (!Run_en) begin
          state_d = ST_STOP;
          pflag_d = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_STOP: begin
        if (tc) begin
          state_d = ST_IDLE;
          if (pflag_q) begin
            active_d = pend_q;
            pflag_d  = 1'b0;
          end else begin
            active_d = active_q;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered status outputs derived from the next state
  always_comb begin
    tick_d  = tc && !div_clk && ((state_q == ST_RUN) || (state_q == ST_PEND));
    ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
  end

  // Controller registers
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      active_q <= N'(DEFAULT_HALF);
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign Cfg_ready   = ready_q;
  assign Clk_o       = div_clk;
  assign Tick_o      = tick_q;
  assign Active_half = active_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_divider_rate_ctrl.sv
// Self-checking bench for divider_rate_ctrl: directed scenarios followed by
// randomized stimulus, all compared against a phase-level reference model.
module tb_divider_rate_ctrl;

  localparam int N  = 16;
  localparam int DH = 4;

  logic         clk_in;
  logic         rst;
  logic         run_en;
  logic         cfg_valid;
  logic [N-1:0] cfg_half;
  logic         cfg_ready;
  logic         clk_o;
  logic         tick_o;
  logic [N-1:0] active_half;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  divider_rate_ctrl #(.N(N), .DEFAULT_HALF(DH)) dut (
    .Clk_in      (clk_in),
    .Rst         (rst),
    .Run_en      (run_en),
    .Cfg_valid   (cfg_valid),
    .Cfg_half    (cfg_half),
    .Cfg_ready   (cfg_ready),
    .Clk_o       (clk_o),
    .Tick_o      (tick_o),
    .Active_half (active_half),
    .Busy        (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- reference model (phase level) ----------------
  // A running clock is described by its level and the cycles left in the
  // current phase; stopping is a request honoured at the next phase end
  // that leaves the clock low; a rate change waits in a queue until a fall.
  int m_half;
  bit m_running;
  bit m_stop;
  bit m_level;
  bit m_tick;
  int m_left;
  int m_pend[$];

  function automatic int clamp(input int h);
    return (h < 2) ? 1 : h;
  endfunction

  function automatic bit m_ready();
    return !m_running || (!m_stop && (m_pend.size() == 0));
  endfunction

  task automatic model_reset();
    m_half    = DH;
    m_running = 1'b0;
    m_stop    = 1'b0;
    m_level   = 1'b0;
    m_tick    = 1'b0;
    m_left    = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    bit acc;
    bit was_stop;
    bit boundary;
    if (rst) begin
      model_reset();
      return;
    end
    acc      = cfg_valid && m_ready();
    was_stop = m_stop;
    m_tick   = 1'b0;
    if (!m_running) begin
      if (acc) m_half = clamp(int'(cfg_half));
      if (run_en) begin
        m_running = 1'b1;
        m_level   = 1'b0;
        m_left    = m_half;
      end
    end else begin
      boundary = (m_left == 1);
      if (boundary && was_stop) begin
        m_running = 1'b0;
        m_stop    = 1'b0;
        m_level   = 1'b0;
        m_left    = 0;
        if (m_pend.size() > 0) m_half = m_pend.pop_front();
      end else begin
        if (boundary) begin
          if (!m_level) begin
            m_level = 1'b1;
            m_tick  = 1'b1;
          end else begin
            m_level = 1'b0;
            if (m_pend.size() > 0) m_half = m_pend.pop_front();
          end
          m_left = m_half;
        end else begin
          m_left--;
        end
        if (!was_stop) begin
          if (acc) m_pend.push_back(clamp(int'(cfg_half)));
          if (!run_en) m_stop = 1'b1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("clk_o",  {31'd0, clk_o},       {31'd0, m_level});
    chk("tick_o", {31'd0, tick_o},      {31'd0, m_tick});
    chk("active", {16'd0, active_half}, m_half);
    chk("busy",   {31'd0, busy},        {31'd0, m_running});
    chk("ready",  {31'd0, cfg_ready},   {31'd0, m_ready()});
  endtask

  // One Clk_in cycle: inputs already set; model steps on the edge,
  // outputs are compared on the following falling edge.
  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic wait_level(input logic lvl, input string tag, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while ((clk_o !== lvl) && (n < 100));
    if (clk_o !== lvl) chk({"timeout_", tag}, {31'd0, clk_o}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((busy !== 1'b0) && (n < 100));
    if (busy !== 1'b0) chk({"timeout_", tag}, {31'd0, busy}, 32'd0);
  endtask

  task automatic offer(input int h);
    cfg_valid = 1'b1;
    cfg_half  = N'(h);
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_clk",    {31'd0, clk_o},       32'd0);
    chk("rst_tick",   {31'd0, tick_o},      32'd0);
    chk("rst_active", {16'd0, active_half}, 32'd4);
    chk("rst_ready",  {31'd0, cfg_ready},   32'd1);
    chk("rst_busy",   {31'd0, busy},        32'd0);
    rst = 1'b0;

    // start at the default half-period of 4
    run_en = 1'b1;
    wait_level(1'b1, "first_rise", n);
    chk("first_rise_delay", n - 1, 32'd4);
    chk("first_tick", {31'd0, tick_o}, 32'd1);
    wait_level(1'b0, "hi4", n);
    chk("high_len4", n, 32'd4);
    wait_level(1'b1, "lo4", n);
    chk("low_len4", n, 32'd4);

    // rate change offered in the high phase
    offer(2);
    chk("ready_drop", {31'd0, cfg_ready}, 32'd0);
    wait_level(1'b0, "hi_old", n);
    chk("high_before_rate", n + 1, 32'd4);
    chk("active_at_fall", {16'd0, active_half}, 32'd2);
    wait_level(1'b1, "lo2", n);
    chk("low_len2", n, 32'd2);
    wait_level(1'b0, "hi2", n);
    chk("high_len2", n, 32'd2);

    // stop, then half of 0 in IDLE clamps to 1
    run_en = 1'b0;
    wait_idle("stop1");
    offer(0);
    chk("active_min", {16'd0, active_half}, 32'd1);
    run_en = 1'b1;
    wait_level(1'b1, "r1", n);
    wait_level(1'b0, "h1", n);
    chk("high_len1", n, 32'd1);
    wait_level(1'b1, "l1", n);
    chk("low_len1", n, 32'd1);

    // Run_en drops mid-high phase at half 5
    run_en = 1'b0;
    wait_idle("stop2");
    offer(5);
    run_en = 1'b1;
    wait_level(1'b1, "r5", n);
    run_en = 1'b0;
    cycle();
    wait_level(1'b0, "h5", n);
    chk("high_before_stop", n + 1, 32'd5);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stay_low", {31'd0, clk_o}, 32'd0);
      chk("no_tick",  {31'd0, tick_o}, 32'd0);
    end

    // config accepted in RUN, then stop before the fall
    run_en = 1'b1;
    wait_level(1'b1, "r5b", n);
    offer(3);
    run_en = 1'b0;
    wait_idle("stop3");
    chk("active_after_stop", {16'd0, active_half}, 32'd3);
    run_en = 1'b1;
    wait_level(1'b1, "r3", n);
    chk("restart_delay", n - 1, 32'd3);
    wait_level(1'b0, "h3", n);
    chk("high_len3", n, 32'd3);

    // async reset while PEND with the divided clock high
    wait_level(1'b1, "l3", n);
    offer(6);
    chk("pend_clk_high", {31'd0, clk_o}, 32'd1);
    chk("pend_ready",    {31'd0, cfg_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_clk",    {31'd0, clk_o},       32'd0);
    chk("arst_tick",   {31'd0, tick_o},      32'd0);
    chk("arst_active", {16'd0, active_half}, 32'd4);
    chk("arst_ready",  {31'd0, cfg_ready},   32'd1);
    model_reset();
    run_en = 1'b0;
    cycle();
    rst    = 1'b0;
    run_en = 1'b1;
    wait_level(1'b1, "rr", n);
    chk("post_rst_delay", n - 1, 32'd4);
    wait_level(1'b0, "hr", n);
    chk("post_rst_high", n, 32'd4);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) run_en = ~run_en;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_half  = N'($urandom_range(0, 6));
      rst       = ($urandom_range(0, 699) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
